// File: rtl/audio_pkg.sv
// Shared I2S framing constants and the channel-index mapping used by the
// receiver and by downstream channel-mapping logic.
package audio_pkg;

    localparam int I2S_BITS_PER_FRAME = 64;
    localparam int I2S_SLOT_BITS      = 32;
    localparam int LEFT_SLOT          = 0;
    localparam int RIGHT_SLOT         = 1;

    // Channel index of (line, slot): lines are interleaved L/R when stereo.
    function automatic int sample_idx(input int line, input int slot, input int stereo);
        return (stereo != 0) ? (line * 2 + slot) : line;
    endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// Shared BCLK/WS generator: divides the audio clock into bit periods, counts
// 64 bits per frame and emits one-cycle strobes for data sampling and frame end.
module i2s_clock_gen
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic       bclk_o,
    output logic       ws_o,
    output logic [5:0] bit_cnt_o,
    output logic       sample_stb_o,
    output logic       frame_done_stb_o
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [5:0]       BIT_LAST = 6'(I2S_BITS_PER_FRAME - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic             bclk_q, bclk_d;
    logic             ws_q, ws_d;

    // Next-state for divider and bit counter; disable parks both at zero.
    always_comb begin
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (!en_i) begin
            div_cnt_d = '0;
            bit_cnt_d = 6'd0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            bit_cnt_d = bit_cnt_q + 6'd1;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
        // Outputs registered from next-state so they track the counters without decode glitches.
        bclk_d = en_i && (div_cnt_d >= DIV_HALF);
        ws_d   = en_i && bit_cnt_d[5];
    end

    // Counter and clock-output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            bit_cnt_q <= 6'd0;
            bclk_q    <= 1'b0;
            ws_q      <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            bclk_q    <= bclk_d;
            ws_q      <= ws_d;
        end
    end

    assign bclk_o           = bclk_q;
    assign ws_o             = ws_q;
    assign bit_cnt_o        = bit_cnt_q;
    assign sample_stb_o     = en_i && (div_cnt_q == DIV_LAST);
    assign frame_done_stb_o = sample_stb_o && (bit_cnt_q == BIT_LAST);

endmodule

// File: rtl/i2s_mic_array_rx.sv
// Multi-line I2S microphone receiver: one shared BCLK/WS pair, per-line
// deserialisers, and a frame-wide output register with valid/ready and overrun.
module i2s_mic_array_rx
    import audio_pkg::*;
#(
    parameter int N_LINES  = 3,
    parameter int STEREO   = 0,
    parameter int DATA_W   = 24,
    parameter int SAMPLE_W = 16,
    parameter int CLK_DIV  = 32
) (
    input  logic                                             clk_in,
    input  logic                                             rst_in,
    input  logic                                             en_in,
    input  logic [N_LINES-1:0]                               mic_data_in,
    output logic                                             bclk_out,
    output logic                                             ws_out,
    output logic [N_LINES*((STEREO != 0) ? 2 : 1)*SAMPLE_W-1:0] samples_out,
    output logic                                             valid_out,
    input  logic                                             ready_in,
    output logic                                             overrun_out,
    input  logic                                             overrun_clr_in
);

    localparam int N_SLOTS = (STEREO != 0) ? 2 : 1;
    localparam int N_CH    = N_LINES * N_SLOTS;
    localparam int VEC_W   = N_CH * SAMPLE_W;

    logic [N_LINES-1:0] sync1_q, sync2_q;
    logic [5:0]         bit_cnt_s;
    logic               sample_stb_s, frame_done_s;
    logic [VEC_W-1:0]   frame_s;

    logic [VEC_W-1:0]   samples_q, samples_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;

    i2s_clock_gen #(.CLK_DIV(CLK_DIV)) u_clock_gen (
        .clk_i            (clk_in),
        .rst_ni           (rst_in),
        .en_i             (en_in),
        .bclk_o           (bclk_out),
        .ws_o             (ws_out),
        .bit_cnt_o        (bit_cnt_s),
        .sample_stb_o     (sample_stb_s),
        .frame_done_stb_o (frame_done_s)
    );

    // Two-stage synchroniser for the asynchronous mic data pins.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= mic_data_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < N_LINES; g++) begin : g_line
        logic [DATA_W-1:0] shift_q, shift_d;
        logic              in_slot_s;

        assign in_slot_s =
            ((bit_cnt_s >= 6'd1) && (bit_cnt_s <= 6'(DATA_W))) ||
            ((STEREO != 0) && (bit_cnt_s >= 6'(I2S_SLOT_BITS + 1)) &&
             (bit_cnt_s <= 6'(I2S_SLOT_BITS + DATA_W)));

        // Shift in one data bit per BCLK during the active slot bits.
        always_comb begin
            if (!en_in) begin
                shift_d = '0;
            end else if (sample_stb_s && in_slot_s) begin
                shift_d = (shift_q << 1) | DATA_W'(sync2_q[g]);
            end else begin
                shift_d = shift_q;
            end
        end

        // Per-line shift register.
        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                shift_q <= '0;
            end else begin
                shift_q <= shift_d;
            end
        end

        for (genvar s = LEFT_SLOT; s < N_SLOTS; s++) begin : g_slot
            localparam int         CH       = sample_idx(g, s, STEREO);
            localparam logic [5:0] LAST_BIT = 6'(s * I2S_SLOT_BITS + DATA_W);
            logic [SAMPLE_W-1:0] hold_q, hold_d;

            // Capture the top bits after the slot's last bit; uses next-state so a
            // slot ending on bit 63 is still included in that frame.
            always_comb begin
                if (!en_in) begin
                    hold_d = '0;
                end else if (sample_stb_s && (bit_cnt_s == LAST_BIT)) begin
                    hold_d = shift_d[DATA_W-1 -: SAMPLE_W];
                end else begin
                    hold_d = hold_q;
                end
            end

            // Per-channel holding register.
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    hold_q <= '0;
                end else begin
                    hold_q <= hold_d;
                end
            end

            assign frame_s[CH*SAMPLE_W +: SAMPLE_W] = hold_d;
        end
    end

    // Output register, handshake and sticky overrun next-state.
    always_comb begin
        samples_d = samples_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (frame_done_s) begin
            if (!valid_q || ready_in) begin
                samples_d = frame_s;
                valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        // A clear never masks an overrun raised in the same cycle.
        if (overrun_clr_in && !(frame_done_s && valid_q && !ready_in)) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_d;
        end
    end

    // Output-side registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            samples_q <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            samples_q <= samples_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign samples_out = samples_q;
    assign valid_out   = valid_q;
    assign overrun_out = overrun_q;

endmodule

// File: tb/tb_i2s_mic_array_rx.sv
// Bench for i2s_mic_array_rx: behavioural I2S mic models with random words
// and a frame-level expected-value queue.
module tb_i2s_mic_array_rx;

    localparam int N_LINES  = 3;
    localparam int STEREO   = 1;
    localparam int DATA_W   = 24;
    localparam int SAMPLE_W = 16;
    localparam int CLK_DIV  = 8;
    localparam int N_CH     = N_LINES * 2;
    localparam int VW       = N_CH * SAMPLE_W;
    localparam int FRAME    = 64 * CLK_DIV;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               en_in;
    logic [N_LINES-1:0] mic_data_in;
    logic               bclk_out, ws_out, valid_out, overrun_out;
    logic [VW-1:0]      samples_out;
    logic               ready_in, overrun_clr_in;

    always #5 clk_in = ~clk_in;

    i2s_mic_array_rx #(
        .N_LINES(N_LINES), .STEREO(STEREO), .DATA_W(DATA_W),
        .SAMPLE_W(SAMPLE_W), .CLK_DIV(CLK_DIV)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .mic_data_in(mic_data_in),
        .bclk_out(bclk_out), .ws_out(ws_out), .samples_out(samples_out),
        .valid_out(valid_out), .ready_in(ready_in), .overrun_out(overrun_out),
        .overrun_clr_in(overrun_clr_in)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- mic model and expected frames ----------------
    logic [DATA_W-1:0] cur_l [N_LINES];
    logic [DATA_W-1:0] cur_r [N_LINES];
    logic [DATA_W-1:0] fix_l [N_LINES];
    logic [DATA_W-1:0] fix_r [N_LINES];
    logic              use_fixed = 1'b0;
    int                pos = 0;
    logic              ws_prev = 1'b0;
    logic [VW-1:0]     frame_q [$];

    task automatic pick_left();
        for (int l = 0; l < N_LINES; l++) cur_l[l] = use_fixed ? fix_l[l] : DATA_W'($urandom);
    endtask

    task automatic pick_right();
        for (int l = 0; l < N_LINES; l++) cur_r[l] = use_fixed ? fix_r[l] : DATA_W'($urandom);
    endtask

    function automatic logic [VW-1:0] build_frame();
        logic [VW-1:0] v = '0;
        for (int l = 0; l < N_LINES; l++) begin
            v[(2*l)*SAMPLE_W +: SAMPLE_W]   = SAMPLE_W'(cur_l[l] >> (DATA_W - SAMPLE_W));
            v[(2*l+1)*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(cur_r[l] >> (DATA_W - SAMPLE_W));
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] last_frame();
        if (frame_q.size() > 0) return frame_q[frame_q.size()-1];
        return 'x;
    endfunction

    // Mic behaviour: change data after each BCLK fall, MSB one bit after WS changes.
    initial begin
        mic_data_in = '0;
        forever begin
            @(negedge bclk_out);
            #1;
            if (en_in && rst_in) begin
                if (ws_out != ws_prev) begin
                    ws_prev = ws_out;
                    pos = 0;
                    if (ws_out) pick_right();
                    else begin
                        frame_q.push_back(build_frame());
                        pick_left();
                    end
                end else begin
                    pos++;
                end
                for (int l = 0; l < N_LINES; l++) begin
                    logic [DATA_W-1:0] w;
                    w = ws_prev ? cur_r[l] : cur_l[l];
                    mic_data_in[l] = (pos >= 1 && pos <= DATA_W) ? w[DATA_W-pos] : 1'($urandom_range(0, 1));
                end
            end
        end
    end

    task automatic start_capture();
        @(negedge clk_in);
        pos = 0;
        ws_prev = 1'b0;
        pick_left();
        en_in = 1'b1;
    endtask

    task automatic stop_capture();
        @(negedge clk_in);
        en_in = 1'b0;
        repeat (10) @(negedge clk_in);
    endtask

    task automatic wait_valid(input string tag, input int budget, output int lat);
        lat = 0;
        while (!valid_out && lat < budget) begin
            @(negedge clk_in);
            lat++;
        end
        if (!valid_out) check_val({tag, "_timeout"}, 128'd0, 128'd1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int cyc;
        int bad;
        logic pb, pw;
        int br [$];
        int wr [$];
        logic [VW-1:0] exp_fix;

        rst_in = 1'b0; en_in = 1'b0; ready_in = 1'b0; overrun_clr_in = 1'b0;
        fix_l[0] = 24'h7FFF12; fix_l[1] = 24'h800001; fix_l[2] = 24'h123456;
        fix_r[0] = 24'hAAAA00; fix_r[1] = 24'h555500; fix_r[2] = 24'hFEDCBA;
        exp_fix = {16'hFEDC, 16'h1234, 16'h5555, 16'h8000, 16'hAAAA, 16'h7FFF};

        // Reset state
        repeat (3) @(negedge clk_in);
        check_val("rst_bclk",    128'(bclk_out),    128'd0);
        check_val("rst_ws",      128'(ws_out),      128'd0);
        check_val("rst_valid",   128'(valid_out),   128'd0);
        check_val("rst_overrun", 128'(overrun_out), 128'd0);
        check_val("rst_samples", 128'(samples_out), 128'd0);

        // Idle with enable low
        rst_in = 1'b1;
        bad = 0;
        repeat (10000) begin
            @(negedge clk_in);
            if (bclk_out || ws_out || valid_out || overrun_out) bad = 1;
        end
        check_val("idle_quiet", 128'(bad), 128'd0);

        // Clocking
        ready_in = 1'b1;
        start_capture();
        cyc = 0; bad = 0; pb = 1'b0; pw = 1'b0;
        repeat (3 * FRAME) begin
            @(negedge clk_in);
            cyc++;
            if (bclk_out && !pb) br.push_back(cyc);
            if (ws_out && !pw) wr.push_back(cyc);
            if ((ws_out != pw) && !(pb && !bclk_out)) bad++;
            pb = bclk_out; pw = ws_out;
        end
        if (br.size() >= 2) check_val("bclk_period", 128'(br[1] - br[0]), 128'(CLK_DIV));
        else check_val("bclk_edges", 128'(br.size()), 128'd2);
        if (wr.size() >= 2) check_val("ws_period", 128'(wr[1] - wr[0]), 128'(FRAME));
        else check_val("ws_edges", 128'(wr.size()), 128'd2);
        check_val("ws_on_bclk_fall", 128'(bad), 128'd0);
        stop_capture();
        check_val("dis_bclk", 128'(bclk_out), 128'd0);
        check_val("dis_ws",   128'(ws_out),   128'd0);

        // Fixed-pattern frames and first-frame latency
        use_fixed = 1'b1;
        frame_q.delete();
        start_capture();
        wait_valid("fixed1", FRAME + 20, lat);
        check_val("first_latency", 128'(lat >= FRAME && lat <= FRAME + 1), 128'd1);
        check_val("fixed1_model", 128'(samples_out), 128'(last_frame()));
        check_val("fixed1_const", 128'(samples_out), 128'(exp_fix));
        check_val("fixed1_overrun", 128'(overrun_out), 128'd0);
        @(negedge clk_in);
        check_val("valid_drop", 128'(valid_out), 128'd0);
        wait_valid("fixed2", FRAME + 20, lat);
        check_val("fixed2_const", 128'(samples_out), 128'(exp_fix));
        @(negedge clk_in);

        // Random frames
        use_fixed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_valid("rand", FRAME + 20, lat);
            check_val($sformatf("rand%0d", i), 128'(samples_out), 128'(last_frame()));
            @(negedge clk_in);
        end

        // Backpressure and overrun
        stop_capture();
        ready_in = 1'b0;
        frame_q.delete();
        start_capture();
        cyc = 0;
        while (frame_q.size() < 3 && cyc < 4 * FRAME) begin
            @(negedge clk_in);
            cyc++;
        end
        check_val("bp_frames", 128'(frame_q.size()), 128'd3);
        check_val("bp_valid", 128'(valid_out), 128'd1);
        check_val("bp_held", 128'(samples_out), 128'(frame_q[0]));
        check_val("bp_overrun", 128'(overrun_out), 128'd1);
        ready_in = 1'b1;
        overrun_clr_in = 1'b1;
        @(negedge clk_in);
        overrun_clr_in = 1'b0;
        check_val("bp_consumed", 128'(valid_out), 128'd0);
        check_val("bp_clr", 128'(overrun_out), 128'd0);
        wait_valid("bp_next", FRAME + 20, lat);
        check_val("bp_next_data", 128'(samples_out), 128'(last_frame()));
        @(negedge clk_in);

        // Mid-frame disable then restart
        stop_capture();
        frame_q.delete();
        start_capture();
        repeat (20 * CLK_DIV) @(negedge clk_in);
        en_in = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk_in);
            if (valid_out || bclk_out || ws_out) bad = 1;
        end
        check_val("middis_quiet", 128'(bad), 128'd0);
        check_val("middis_nopush", 128'(frame_q.size()), 128'd0);
        start_capture();
        wait_valid("middis_frame", FRAME + 20, lat);
        check_val("middis_latency", 128'(lat >= FRAME && lat <= FRAME + 1), 128'd1);
        check_val("middis_data", 128'(samples_out), 128'(last_frame()));
        @(negedge clk_in);

        // Mid-frame reset then restart
        frame_q.delete();
        repeat (20 * CLK_DIV) @(negedge clk_in);
        en_in = 1'b0;
        rst_in = 1'b0;
        #1;
        check_val("midrst_samples", 128'(samples_out), 128'd0);
        check_val("midrst_bclk", 128'(bclk_out), 128'd0);
        check_val("midrst_valid", 128'(valid_out), 128'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (5) @(negedge clk_in);
        frame_q.delete();
        start_capture();
        wait_valid("midrst_frame", FRAME + 20, lat);
        check_val("midrst_latency", 128'(lat >= FRAME && lat <= FRAME + 1), 128'd1);
        check_val("midrst_data", 128'(samples_out), 128'(last_frame()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
